// File: rtl/gate_sweep_pkg.sv
// Shared types and constants for the two-output gate sweep controller.
// The truth tables are indexed by the input vector i = {a,b}.
package gate_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } sweep_state_e;

    localparam int unsigned NUM_VEC  = 4;
    localparam logic [1:0]  VEC_LAST = 2'(NUM_VEC - 1);
    localparam logic [3:0]  ERR_MAX  = 4'd8;

    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_XNOR = 4'b1001;

    // Eight samples per sweep bound the count anyway; the clamp keeps it
    // safe if the sweep length ever grows.
    function automatic logic [3:0] err_add_sat(input logic [3:0] acc, input logic [1:0] inc);
        logic [4:0] sum;
        sum = {1'b0, acc} + {3'b000, inc};
        return (sum > {1'b0, ERR_MAX}) ? ERR_MAX : sum[3:0];
    endfunction

endpackage

// File: rtl/gate_sweep_cmp.sv
// Combinational comparison of both gate outputs against their expected bits
// for the current vector.
module gate_sweep_cmp
    import gate_sweep_pkg::*;
(
    input  logic               y1,
    input  logic               y2,
    input  logic               exp_y1,
    input  logic               exp_y2,
    input  logic [1:0]         vec,
    output logic [1:0]         mis_cnt,
    output logic               mis_flag,
    output logic [NUM_VEC-1:0] mis_map
);

    logic mis_y1;
    logic mis_y2;

    always_comb begin
        mis_y1       = y1 ^ exp_y1;
        mis_y2       = y2 ^ exp_y2;
        mis_cnt      = {1'b0, mis_y1} + {1'b0, mis_y2};
        mis_flag     = mis_y1 | mis_y2;
        mis_map      = '0;
        mis_map[vec] = mis_flag;
    end

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Sweeps {a,b} through all four input vectors of an external two-output gate,
// checks y1/y2 against expected truth tables and reports a pass/fail summary.
module gate_sweep_ctrl
    import gate_sweep_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = 2,
    parameter logic [3:0]  EXP_Y1     = TT_AND,
    parameter logic [3:0]  EXP_Y2     = TT_NAND
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       y1,
    input  logic       y2,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_map,
    output logic [3:0] err_cnt
);

    localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYC - 1);

    sweep_state_e       state_q, state_d;
    logic [1:0]         vec_q, vec_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [NUM_VEC-1:0] fail_map_q, fail_map_d;
    logic [3:0]         err_cnt_q, err_cnt_d;
    logic               pass_q, pass_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               a_q, a_d;
    logic               b_q, b_d;

    logic [1:0]         mis_cnt;
    logic               mis_flag;
    logic [NUM_VEC-1:0] mis_map;

    gate_sweep_cmp u_cmp (
        .y1       (y1),
        .y2       (y2),
        .exp_y1   (EXP_Y1[vec_q]),
        .exp_y2   (EXP_Y2[vec_q]),
        .vec      (vec_q),
        .mis_cnt  (mis_cnt),
        .mis_flag (mis_flag),
        .mis_map  (mis_map)
    );

    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        cnt_d      = cnt_q;
        fail_map_d = fail_map_q;
        err_cnt_d  = err_cnt_q;
        pass_d     = pass_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = SETTLE;
                    vec_d      = '0;
                    cnt_d      = '0;
                    fail_map_d = '0;
                    err_cnt_d  = '0;
                    pass_d     = 1'b0;
                end
            end
            SETTLE: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == CNT_LAST) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                fail_map_d = fail_map_q | mis_map;
                if (mis_flag) begin
                    err_cnt_d = err_add_sat(err_cnt_q, mis_cnt);
                end
                if (vec_q == VEC_LAST) begin
                    state_d = DONE;
                end else begin
                    vec_d   = vec_q + 2'd1;
                    cnt_d   = '0;
                    state_d = SETTLE;
                end
            end
            DONE: begin
                pass_d  = (fail_map_q == '0);
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Drive and status flops are loaded from the next state so they line
        // up with the state register instead of lagging it by a cycle.
        busy_d = (state_d == SETTLE) || (state_d == SAMPLE);
        done_d = (state_d == DONE);
        a_d    = busy_d & vec_d[1];
        b_d    = busy_d & vec_d[0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            vec_q      <= '0;
            cnt_q      <= '0;
            fail_map_q <= '0;
            err_cnt_q  <= '0;
            pass_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            a_q        <= 1'b0;
            b_q        <= 1'b0;
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            cnt_q      <= cnt_d;
            fail_map_q <= fail_map_d;
            err_cnt_q  <= err_cnt_d;
            pass_q     <= pass_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            a_q        <= a_d;
            b_q        <= b_d;
        end
    end

    assign a        = a_q;
    assign b        = b_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign fail_map = fail_map_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Scoreboard bench: two controllers (AND/NAND default, XOR/XNOR fast settle)
// driving behavioural gates with injectable per-vector output faults.
module tb_gate_sweep_ctrl;
    import gate_sweep_pkg::*;

    typedef struct {
        int         c0;
        logic [3:0] fm;
        logic [3:0] ec;
        logic       ps;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start0 = 1'b0;
    logic start1 = 1'b0;

    logic [3:0] f1_0 = '0, f2_0 = '0, f1_1 = '0, f2_1 = '0;

    logic a0, b0, busy0, done0, pass0, y1_0, y2_0;
    logic a1, b1, busy1, done1, pass1, y1_1, y2_1;
    logic [3:0] fm0, ec0, fm1, ec1;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_c0 = 0;

    exp_t q0[$];
    exp_t q1[$];
    int         pend_cyc[2] = '{-1, -1};
    logic [3:0] pend_fm[2];
    logic [3:0] pend_ec[2];
    logic       pend_ps[2];

    // Gates under test; a set fault bit inverts that output on that vector.
    assign y1_0 = (a0 & b0) ^ f1_0[{a0, b0}];
    assign y2_0 = ~(a0 & b0) ^ f2_0[{a0, b0}];
    assign y1_1 = (a1 ^ b1) ^ f1_1[{a1, b1}];
    assign y2_1 = ~(a1 ^ b1) ^ f2_1[{a1, b1}];

    gate_sweep_ctrl dut0 (
        .clk(clk), .rst(rst), .start(start0), .y1(y1_0), .y2(y2_0),
        .a(a0), .b(b0), .busy(busy0), .done(done0), .pass(pass0),
        .fail_map(fm0), .err_cnt(ec0)
    );

    gate_sweep_ctrl #(.SETTLE_CYC(1), .EXP_Y1(4'b0110), .EXP_Y2(TT_XNOR)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .y1(y1_1), .y2(y2_1),
        .a(a1), .b(b1), .busy(busy1), .done(done1), .pass(pass1),
        .fail_map(fm1), .err_cnt(ec1)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input int id, input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s dut%0d cyc=%0d actual=%0d expected=%0d", name, id, cyc, act, exp);
        end
    endtask

    task automatic mon_step(input int id, input int s, input logic busy, input logic done,
                            input logic a, input logic b, input logic pass,
                            input logic [3:0] fm, input logic [3:0] ec);
        exp_t e;
        bit   have;
        int   len;
        have = 1'b0;
        if (id == 0 && q0.size() > 0) begin e = q0[0]; have = 1'b1; end
        if (id == 1 && q1.size() > 0) begin e = q1[0]; have = 1'b1; end
        len = 4 * (s + 1);
        if (have && cyc >= e.c0 && cyc < e.c0 + len) begin
            chk(id, "busy_in_sweep", int'(busy), 1);
            chk(id, "ab_vector", int'({a, b}), (cyc - e.c0) / (s + 1));
        end else begin
            chk(id, "busy_idle", int'(busy), 0);
            chk(id, "ab_idle", int'({a, b}), 0);
        end
        if (have && cyc == e.c0) begin
            chk(id, "pass_cleared", int'(pass), 0);
            chk(id, "fm_cleared", int'(fm), 0);
            chk(id, "ec_cleared", int'(ec), 0);
        end
        if (have && cyc == e.c0 + len) begin
            chk(id, "done_pulse", int'(done), 1);
            chk(id, "fail_map", int'(fm), int'(e.fm));
            chk(id, "err_cnt", int'(ec), int'(e.ec));
            pend_cyc[id] = cyc + 1;
            pend_fm[id]  = e.fm;
            pend_ec[id]  = e.ec;
            pend_ps[id]  = e.ps;
            if (id == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        end else begin
            chk(id, "no_done", int'(done), 0);
        end
        if (pend_cyc[id] == cyc) begin
            chk(id, "pass", int'(pass), int'(pend_ps[id]));
            chk(id, "fm_hold", int'(fm), int'(pend_fm[id]));
            chk(id, "ec_hold", int'(ec), int'(pend_ec[id]));
            pend_cyc[id] = -1;
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
        #1;
        mon_step(0, 2, busy0, done0, a0, b0, pass0, fm0, ec0);
        mon_step(1, 1, busy1, done1, a1, b1, pass1, fm1, ec1);
    end

    task automatic launch(input int id, input logic [3:0] f1, input logic [3:0] f2);
        exp_t e;
        @(negedge clk);
        e.c0 = cyc + 1;
        e.fm = f1 | f2;
        e.ec = 4'($countones(f1) + $countones(f2));
        e.ps = (e.fm == 4'd0);
        last_c0 = e.c0;
        if (id == 0) begin
            f1_0 = f1; f2_0 = f2; start0 = 1'b1; q0.push_back(e);
        end else begin
            f1_1 = f1; f2_1 = f2; start1 = 1'b1; q1.push_back(e);
        end
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic wait_idle(input int id);
        int n;
        n = 0;
        while (((id == 0) ? q0.size() : q1.size()) != 0 || pend_cyc[id] != -1) begin
            @(negedge clk);
            n++;
            if (n > 200) begin
                checks++;
                failures++;
                $display("FAIL sweep_timeout dut%0d cyc=%0d actual=no_done expected=done", id, cyc);
                if (id == 0) q0.delete(); else q1.delete();
                pend_cyc[id] = -1;
                break;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk(0, "rst_pass", int'(pass0), 0);
        chk(0, "rst_fm", int'(fm0), 0);
        chk(0, "rst_ec", int'(ec0), 0);
        chk(1, "rst_pass", int'(pass1), 0);
        chk(1, "rst_fm", int'(fm1), 0);
        chk(1, "rst_ec", int'(ec1), 0);

        // Clean AND/NAND, y1 stuck-at-1, outputs swapped
        launch(0, 4'b0000, 4'b0000); wait_idle(0);
        launch(0, ~TT_AND, 4'b0000); wait_idle(0);
        launch(0, 4'b1111, 4'b1111); wait_idle(0);

        // Re-pulsed start at edges 3 and 12, and while in DONE (edge 13)
        launch(0, 4'b0000, 4'b0000);
        while (cyc < last_c0 + 13) begin
            start0 = (cyc == last_c0 + 2) || (cyc == last_c0 + 11) || (cyc == last_c0 + 12);
            @(negedge clk);
        end
        start0 = 1'b0;
        wait_idle(0);
        repeat (3) @(negedge clk);

        // Abort at edge 5, then start together with reset, then a clean sweep
        launch(0, 4'b0101, 4'b0000);
        while (cyc < last_c0 + 4) @(negedge clk);
        rst = 1'b1;
        q0.delete();
        @(negedge clk);
        rst = 1'b0;
        chk(0, "abort_fm", int'(fm0), 0);
        chk(0, "abort_ec", int'(ec0), 0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        start0 = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start0 = 1'b0;
        repeat (5) @(negedge clk);
        launch(0, 4'b0000, 4'b0000); wait_idle(0);

        repeat (10) begin
            launch(0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            wait_idle(0);
        end

        // XOR gate on the fast-settle controller
        launch(1, 4'b0000, 4'b0000); wait_idle(1);
        repeat (4) begin
            launch(1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            wait_idle(1);
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
